// File: rtl/two_bit_mux_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : two_bit_mux_arbiter
//  Description : Round-robin, burst-limited arbiter that shares a 2-bit mux
//                datapath between requesters A and B. Drives a registered
//                mux select and a registered output word with a valid strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module two_bit_mux_arbiter #(
   parameter int unsigned MAX_BURST = 4   // transfers per grant, 1..15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_a,
   input  logic [1:0] data_a,
   input  logic       req_b,
   input  logic [1:0] data_b,
   output logic       gnt_a,
   output logic       gnt_b,
   output logic       sel,
   output logic [1:0] out_data,
   output logic       out_valid
);

   // Arbiter states
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_GRANT_A = 2'd1;
   localparam logic [1:0] ST_GRANT_B = 2'd2;

   // Owner encoding shared by the last pointer; matches the sel polarity
   localparam logic C_OWNER_A = 1'b1;
   localparam logic C_OWNER_B = 1'b0;

   localparam logic [3:0] C_MAX_BURST = 4'(MAX_BURST);

   logic [1:0] state_q,     state_d;
   logic       sel_q,       sel_d;
   logic [3:0] cnt_q,       cnt_d;
   logic       last_q,      last_d;
   logic       out_valid_q, out_valid_d;
   logic [1:0] out_data_q,  out_data_d;

   // Current owner's view of the requesters, valid only in a GRANT state
   logic       w_is_a;
   logic       w_own_req;
   logic       w_oth_req;
   logic [1:0] w_own_data;
   logic [3:0] w_cnt_inc;
   logic       w_release;

   assign w_is_a     = (state_q == ST_GRANT_A);
   assign w_own_req  = w_is_a ? req_a  : req_b;
   assign w_oth_req  = w_is_a ? req_b  : req_a;
   assign w_own_data = w_is_a ? data_a : data_b;
   assign w_cnt_inc  = cnt_q + 4'd1;
   // A dropped request releases without a transfer; otherwise the transfer
   // that reaches the burst limit releases.
   assign w_release  = !w_own_req || (w_cnt_inc == C_MAX_BURST);

   // Next-state, grant hand-over, burst counting and output word capture
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;

      case (state_q)
         ST_IDLE: begin
            // A wins if alone, or on a tie when B was the last owner
            if (req_a && (!req_b || (last_q == C_OWNER_B))) begin
               state_d = ST_GRANT_A;
               sel_d   = 1'b1;
               cnt_d   = 4'd0;
            end else if (req_b) begin
               state_d = ST_GRANT_B;
               sel_d   = 1'b0;
               cnt_d   = 4'd0;
            end
         end

         ST_GRANT_A, ST_GRANT_B: begin
            if (w_own_req) begin
               out_valid_d = 1'b1;
               out_data_d  = w_own_data;
               cnt_d       = w_cnt_inc;
            end
            if (w_release) begin
               last_d = w_is_a ? C_OWNER_A : C_OWNER_B;
               if (w_oth_req) begin
                  // Hand over directly, no idle bubble
                  state_d = w_is_a ? ST_GRANT_B : ST_GRANT_A;
                  sel_d   = !w_is_a;
                  cnt_d   = 4'd0;
               end else if (w_own_req) begin
                  // Burst expired with nobody else waiting: re-grant
                  cnt_d   = 4'd0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         sel_q       <= 1'b0;
         cnt_q       <= 4'd0;
         last_q      <= C_OWNER_B;
         out_valid_q <= 1'b0;
         out_data_q  <= 2'b00;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign gnt_a     = (state_q == ST_GRANT_A);
   assign gnt_b     = (state_q == ST_GRANT_B);
   assign sel       = sel_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_two_bit_mux_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_two_bit_mux_arbiter
//  Description : Self-checking bench for two_bit_mux_arbiter. Each record
//                holds the inputs applied before a rising edge and the
//                outputs expected just after it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_two_bit_mux_arbiter;

   typedef struct {
      logic       rst;
      logic       ra;
      logic [1:0] da;
      logic       rb;
      logic [1:0] db;
      logic       ga;
      logic       gb;
      logic       sel;
      logic       ov;
      logic [1:0] od;
   } vec_t;

   logic       clk;
   logic       reset;
   logic       req_a;
   logic [1:0] data_a;
   logic       req_b;
   logic [1:0] data_b;
   logic       gnt_a;
   logic       gnt_b;
   logic       sel;
   logic [1:0] out_data;
   logic       out_valid;

   int checks;
   int failures;
   vec_t vq[$];

   two_bit_mux_arbiter #(.MAX_BURST(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .req_a    (req_a),
      .data_a   (data_a),
      .req_b    (req_b),
      .data_b   (data_b),
      .gnt_a    (gnt_a),
      .gnt_b    (gnt_b),
      .sel      (sel),
      .out_data (out_data),
      .out_valid(out_valid)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic ra, input logic [1:0] da,
                               input logic rb, input logic [1:0] db,
                               input logic ga, input logic gb, input logic s,
                               input logic ov, input logic [1:0] od);
      vec_t v;
      v.rst = r;  v.ra = ra; v.da = da; v.rb = rb; v.db = db;
      v.ga  = ga; v.gb = gb; v.sel = s; v.ov = ov; v.od = od;
      return v;
   endfunction

   // Apply one record across a rising edge and compare just after it
   task automatic run_vec(input vec_t v, input string name);
      logic [5:0] act;
      logic [5:0] exp;
      reset  = v.rst;
      req_a  = v.ra;
      data_a = v.da;
      req_b  = v.rb;
      data_b = v.db;
      @(posedge clk);
      #1;
      act = {gnt_a, gnt_b, sel, out_valid, out_data};
      exp = {v.ga, v.gb, v.sel, v.ov, v.od};
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got gnt_a/gnt_b/sel/valid/data=%b/%b/%b/%b/%b want %b/%b/%b/%b/%b",
                  name, act[5], act[4], act[3], act[2], act[1:0],
                  exp[5], exp[4], exp[3], exp[2], exp[1:0]);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      req_a    = 1'b0;
      data_a   = 2'b00;
      req_b    = 1'b0;
      data_b   = 2'b00;

      // Reset held two cycles with both requests high, then A wins the tie
      vq.push_back(mk(1,1,0,1,0, 0,0,0,0,0));
      vq.push_back(mk(1,1,0,1,0, 0,0,0,0,0));
      vq.push_back(mk(0,1,0,1,0, 1,0,1,0,0));
      // Contention: A x4, B x4, A x4 with no gap in out_valid
      vq.push_back(mk(0,1,1,1,3, 1,0,1,1,1));
      vq.push_back(mk(0,1,2,1,3, 1,0,1,1,2));
      vq.push_back(mk(0,1,3,1,3, 1,0,1,1,3));
      vq.push_back(mk(0,1,0,1,3, 0,1,0,1,0));
      vq.push_back(mk(0,1,1,1,2, 0,1,0,1,2));
      vq.push_back(mk(0,1,1,1,1, 0,1,0,1,1));
      vq.push_back(mk(0,1,1,1,3, 0,1,0,1,3));
      vq.push_back(mk(0,1,1,1,0, 1,0,1,1,0));
      vq.push_back(mk(0,1,2,1,0, 1,0,1,1,2));
      vq.push_back(mk(0,1,1,1,0, 1,0,1,1,1));
      vq.push_back(mk(0,1,3,1,0, 1,0,1,1,3));
      vq.push_back(mk(0,1,2,0,0, 1,0,1,1,2));
      vq.push_back(mk(0,0,0,0,0, 0,0,1,0,2));
      // Single A burst of two words, sel stays 1 in IDLE
      vq.push_back(mk(0,1,0,0,0, 1,0,1,0,2));
      vq.push_back(mk(0,1,1,0,0, 1,0,1,1,1));
      vq.push_back(mk(0,1,2,0,0, 1,0,1,1,2));
      vq.push_back(mk(0,0,0,0,0, 0,0,1,0,2));
      vq.push_back(mk(0,0,0,0,0, 0,0,1,0,2));
      // Lone B for ten transfers: gnt_b never drops across re-grants
      vq.push_back(mk(0,0,0,1,0, 0,1,0,0,2));
      for (int k = 0; k < 10; k++) begin
         logic [1:0] d;
         d = 2'((k + 1) % 4);
         vq.push_back(mk(0,0,0,1,d, 0,1,0,1,d));
      end
      vq.push_back(mk(0,0,0,0,0, 0,0,0,0,2));
      // Early drop by A while B waits: exactly one valid gap
      vq.push_back(mk(0,1,0,0,0, 1,0,1,0,2));
      vq.push_back(mk(0,1,3,1,1, 1,0,1,1,3));
      vq.push_back(mk(0,0,0,1,1, 0,1,0,0,3));
      vq.push_back(mk(0,0,0,1,2, 0,1,0,1,2));
      vq.push_back(mk(0,0,0,0,0, 0,0,0,0,2));

      foreach (vq[i]) run_vec(vq[i], $sformatf("vec%0d", i));

      // Reset mid-burst after A was the last owner; the next tie must go to A
      run_vec(mk(0,1,0,0,0, 1,0,1,0,2), "rst_grant_a");
      run_vec(mk(0,0,0,0,0, 0,0,1,0,2), "rst_a_drop");
      run_vec(mk(0,1,0,0,0, 1,0,1,0,2), "rst_regrant_a");
      run_vec(mk(0,1,1,0,0, 1,0,1,1,1), "rst_xfer1");
      run_vec(mk(1,1,2,1,3, 0,0,0,0,0), "rst_mid_burst");
      run_vec(mk(0,1,0,1,0, 1,0,1,0,0), "rst_tie_to_a");
      run_vec(mk(0,1,3,1,2, 1,0,1,1,3), "rst_post_xfer");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/two_bit_mux_arbiter.md
# two_bit_mux_arbiter

Round-robin arbiter that shares the 2-bit `two_bit_mux` datapath between two requesters, A and B. It grants one requester at a time and drives the mux `sel` line: `sel=1` passes A, `sel=0` passes B. It registers the selected 2-bit word onto a single output with a valid strobe. Grants are burst-limited so neither requester can starve the other.

## Interface
- `MAX_BURST`, default 4: maximum transfers per grant; legal range 1..15.

- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `req_a`  in  1  requester A wants the datapath
- `data_a`  in  2  requester A word, sampled on transfer cycles
- `req_b`  in  1  requester B wants the datapath
- `data_b`  in  2  requester B word, sampled on transfer cycles
- `gnt_a`  out  1  A owns the datapath this cycle
- `gnt_b`  out  1  B owns the datapath this cycle
- `sel`  out  1  mux select: 1 = A, 0 = B
- `out_data`  out  2  registered selected word
- `out_valid`  out  1  `out_data` holds a transferred word

## Operation
- FSM states: IDLE, GRANT_A, GRANT_B.
  - `gnt_a` = (state==GRANT_A); `gnt_b` = (state==GRANT_B); never both high.
- Internal 1-bit `last` pointer records the most recently released owner. Reset value = B, so A wins the first tie.
- Internal burst counter, 4 bits, cleared on every entry into a GRANT state.
- IDLE:
  - Only one req high → go to that GRANT state.
  - Both high → grant the requester that is not `last`.
  - Neither high → stay in IDLE.
- Transfer cycle = `gnt_x & req_x`.
  - Next cycle: `out_valid`=1 and `out_data` = `data_x` from the transfer cycle.
  - The burst counter increments on each transfer.
- Release conditions, evaluated at the end of a GRANT_x cycle:
  - `req_x`=0 in a granted cycle. No transfer occurs that cycle.
  - A transfer brings the burst count to `MAX_BURST`.
- On release:
  - `last` = x.
  - Next state: the other requester's req high → GRANT_other, with no idle bubble. Otherwise `req_x` high (burst expiry only) → GRANT_x again with the counter cleared. Otherwise → IDLE.
- `sel` is registered.
  - Set to 1 on entry to GRANT_A, set to 0 on entry to GRANT_B.
  - Holds its value in IDLE.
  - Always equals the owner during GRANT states.
- `out_data` holds its last value when `out_valid`=0.

## Timing
- Reset values: state=IDLE, `gnt_a`=0, `gnt_b`=0, `sel`=0, `out_data`=2'b00, `out_valid`=0, counter=0, `last`=B.
- Reset asserted mid-burst: all of the above take effect on the next edge. Any in-flight word is dropped, so `out_valid`=0 in the cycle after reset.
- Latency from IDLE:
  - req seen at edge t → gnt high after edge t+1.
  - First `out_valid` after edge t+2.
- Latency at handover: the last transfer of X at cycle c → gnt of Y high at cycle c+1, with Y's word valid at c+2. Throughput stays at one word per cycle.
- Requesters may change data every granted cycle.
- A requester may drop req at any time. The drop takes effect in that same cycle (no transfer) and costs exactly one bubble cycle before the next owner is granted.
- Both reqs rising in the same cycle as a release: the release rule applies and `last` is updated before the next tie is decided.

## Test plan
- Reset: hold `reset` 2 cycles with both reqs high → all outputs 0 and no gnt. After release, `gnt_a`=1 one cycle later and `sel`=1.
- Single A burst: `req_a` high 2 cycles with `data_a`=2'b01 then 2'b10, then low → `out_valid` for 2 cycles carrying 01 then 10, state returns to IDLE, `sel` stays 1.
- Contention, `MAX_BURST`=4, both reqs held high → grant sequence is A×4, B×4, A×4. Expected B words appear with `sel`=0 and no gap in `out_valid`.
- Lone requester beyond burst: only `req_b` high for 10 cycles → `gnt_b` continuously high (re-grant at count 4 and 8), 10 valid words, `gnt_a` never asserted.
- Early drop: A granted, `req_a` drops after 1 transfer while `req_b` is high → `gnt_b` asserts the next cycle and `out_valid` shows exactly one gap cycle.
- Reset mid-burst: assert `reset` during the 2nd A transfer → the next cycle shows `out_valid`=0, no gnt and `sel`=0. A following tie is granted to A.
